// File: rtl/hack_math_defs.sv
// Shared arithmetic definitions for the 16-bit math blocks: word limits,
// divider state encodings and the iteration bound.
package hack_math_defs;

  localparam int unsigned WORD_WIDTH = 16;
  localparam logic [15:0] WORD_MIN   = 16'h8000;
  localparam logic [15:0] WORD_MAX   = 16'h7FFF;

  // Counter value at which the 16th iteration has completed.
  localparam logic [4:0]  ITER_LAST  = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/add16.sv
// 16-bit ripple adder with carry in/out; subtraction is a + ~b + 1 at the caller.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

// File: rtl/inc16.sv
// 16-bit incrementer, used as the +1 step of two's-complement negation.
module inc16 (
  input  logic [15:0] a,
  output logic [15:0] sum
);

  assign sum = a + 16'd1;

endmodule

// File: rtl/div16_seq.sv
// Sequential signed 16-bit divider: restoring shift-subtract on magnitudes,
// followed by a sign-fix cycle. Fixed 18-cycle busy window for every operand pair.
//
// Handshake: start is sampled only in IDLE; once accepted, busy stays high
// until the edge entering DONE, and done pulses for exactly one cycle there.
module div16_seq
  import hack_math_defs::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output div_state_t       dbg_state
);

  div_state_t       state, state_next;
  logic [4:0]       iter;
  logic [WIDTH-1:0] quo_mag, rem_mag, dvs_mag;
  logic             neg_quo, neg_rem, zero_div, min_neg1;

  logic [WIDTH-1:0] dd_neg, dv_neg, quo_neg, rem_neg;
  logic [WIDTH-1:0] dd_mag, dv_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow, fits, accept;

  inc16 u_neg_dd  (.a(~dividend), .sum(dd_neg));
  inc16 u_neg_dv  (.a(~divisor),  .sum(dv_neg));
  inc16 u_neg_quo (.a(~quo_mag),  .sum(quo_neg));
  inc16 u_neg_rem (.a(~rem_mag),  .sum(rem_neg));

  // An unsigned 16-bit magnitude holds 32768 exactly, so MIN needs no special case.
  assign dd_mag = dividend[WIDTH-1] ? dd_neg : dividend;
  assign dv_mag = divisor[WIDTH-1]  ? dv_neg : divisor;

  // 17-bit partial remainder: previous remainder shifted left, next dividend bit in.
  assign trial = {rem_mag, quo_mag[WIDTH-1]};

  add16 u_trial (
    .a    (trial[WIDTH-1:0]),
    .b    (~dvs_mag),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  assign fits   = trial[WIDTH] | no_borrow;
  assign accept = (state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (iter == ITER_LAST) state_next = ST_FIX;
      end
      ST_FIX: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      iter        <= 5'd0;
      quo_mag     <= '0;
      rem_mag     <= '0;
      dvs_mag     <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      zero_div    <= 1'b0;
      min_neg1    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            iter     <= 5'd0;
            quo_mag  <= dd_mag;
            rem_mag  <= '0;
            dvs_mag  <= dv_mag;
            neg_quo  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem  <= dividend[WIDTH-1];
            zero_div <= (divisor == '0);
            min_neg1 <= (dividend == WORD_MIN) && (divisor == '1);
          end
        end
        ST_CALC: begin
          if (iter != ITER_LAST) begin
            rem_mag <= fits ? diff : trial[WIDTH-1:0];
            quo_mag <= {quo_mag[WIDTH-2:0], fits};
            iter    <= iter + 5'd1;
          end
        end
        ST_FIX: begin
          // With a zero divisor the loop leaves |dividend| in rem_mag, so the
          // normal sign fix restores the dividend; only the quotient is forced.
          quotient    <= zero_div ? '1 : (neg_quo ? quo_neg : quo_mag);
          remainder   <= neg_rem ? rem_neg : rem_mag;
          div_by_zero <= zero_div;
          overflow    <= min_neg1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div16_seq.md
DIV16_SEQ -- requirements
Module: div16_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width; only 16 is verified.
REQ-002 clk  input  1  rising-edge clock, single domain.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 dividend  input  16  signed two's-complement numerator, captured when start is accepted.
REQ-006 divisor  input  16  signed two's-complement denominator, captured when start is accepted.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse when results are valid.
REQ-009 quotient  output  16  signed quotient.
REQ-010 remainder  output  16  signed remainder.
REQ-011 div_by_zero  output  1  error flag for the last division.
REQ-012 overflow  output  1  flag set when the last division was MIN / -1.

Function
REQ-013 States SHALL be IDLE, CALC, FIX and DONE.
REQ-014 Transitions: IDLE->CALC on start; CALC->FIX after exactly 16 iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-015 Start accept: start high at edge k in IDLE; operands are latched at edge k, and their magnitudes and sign bits are recorded.
REQ-016 Busy window: busy is high from edge k through the edge that enters DONE.
REQ-017 CALC: one restoring shift-subtract iteration per cycle on unsigned magnitudes, using a 17-bit partial remainder.
REQ-018 FIX: the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-019 Latency: done is high exactly in the cycle after edge k+18, for one cycle only; latency is fixed for all operand values, including error cases.
REQ-020 Results: quotient, remainder and flags are updated at the edge entering DONE and held until the next accepted start completes.
REQ-021 Rounding: quotient is truncated toward zero; dividend = quotient*divisor + remainder, and |remainder| < |divisor|.
REQ-022 Divisor 0: quotient = 16'hFFFF, remainder = dividend, div_by_zero = 1, overflow = 0.
REQ-023 MIN/-1: dividend = -32768 with divisor = -1 gives quotient = 16'h8000 (wrap), remainder = 0, overflow = 1.
REQ-024 Flags are cleared to 0 for any other operand pair.
REQ-025 Magnitude of MIN (32768) SHALL be represented without loss in the 17-bit datapath.
REQ-026 Start while busy (CALC/FIX/DONE) SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-027 Start in the same cycle as done: done is asserted in DONE, so start is accepted only at the next edge, from IDLE; there is no back-to-back acceptance in DONE.
REQ-028 Operand inputs may change freely after acceptance without affecting the result.

Reset
REQ-029 On reset: state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, overflow = 0, iteration counter = 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation at that edge; no done pulse follows.
REQ-031 Reset SHALL take priority over start at the same edge.

Structure
REQ-032 The shared header hack_math_defs SHALL hold the state encodings, WORD_WIDTH = 16, WORD_MIN = 16'h8000 and WORD_MAX = 16'h7FFF.
REQ-033 The trial subtraction SHALL reuse the existing add16 as the one sub-module, computing a + ~b + 1.
REQ-034 Sign correction SHALL reuse inc16 for the +1 of negation; no behavioural "/" or "%" operators are permitted.
REQ-035 The iteration counter SHALL be 5 bits wide.

Verification
REQ-036 Positive divide: start, 100 / 7 -> quotient 14, remainder 2, done exactly 19 cycles after the start edge, busy high for 18 cycles.
REQ-037 Signed cases:
- -100 / 7 -> quotient -14, remainder -2.
- 100 / -7 -> quotient -14, remainder 2.
- -100 / -7 -> quotient 14, remainder -2.
REQ-038 Edge values:
- -32768 / -1 -> quotient 16'h8000, remainder 0, overflow 1.
- -32768 / 1 -> quotient -32768, flags 0.
- 32767 / -32768 -> quotient 0, remainder 32767.
REQ-039 Divide by zero: 1234 / 0 -> quotient 16'hFFFF, remainder 1234, div_by_zero 1, latency unchanged.
REQ-040 Busy and reset behaviour:
- Start 9 / 3 held continuously, operands changed to 8 / 0 mid-CALC -> single done, quotient 3, remainder 0.
- Reset at cycle 5 of CALC -> all outputs 0, no done pulse.
REQ-041 Random check: 1000 random pairs with nonzero divisor -> quotient*divisor + remainder == dividend (16-bit wrap), |remainder| < |divisor|, and the remainder sign matches the dividend sign or the remainder is 0.
